// File: rtl/count_seq.sv
// Loadable up-counter: starts at init, adds step once per RUN cycle and clamps at limit.
// hold pauses a run, abort cancels it, and done pulses for one cycle when a run completes.
module count_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;
  logic [WIDTH:0]   sum;

  // One extra bit keeps the carry visible, so the compare against limit never sees a wrapped sum.
  assign sum = {1'b0, count_reg} + {1'b0, step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            count_next = init;
            cout_next  = 1'b0;
            ovf_next   = 1'b0;
            if (init >= limit) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (hold) begin
            state_next = HOLD;
          end else begin
            cout_next = sum[WIDTH];
            if (sum >= {1'b0, limit}) begin
              count_next = limit;
              ovf_next   = sum[WIDTH];
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              count_next = sum[WIDTH-1:0];
            end
          end
        end
        HOLD: begin
          if (!hold) state_next = RUN;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign count = count_reg;
  assign cout  = cout_reg;
  assign ovf   = ovf_reg;
  assign done  = done_reg;
  assign busy  = (state_reg == RUN) || (state_reg == HOLD);

endmodule

// File: tb/tb_count_seq.sv
// Randomized scoreboard bench for count_seq: a behavioural run model predicts outputs after each edge,
// and a negedge monitor compares the DUT against the queued predictions.
module tb_count_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [W-1:0] init = '0, step = '0, limit = '0;
  logic [W-1:0] count;
  logic         busy, done, cout, ovf;

  count_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
    .init(init), .step(step), .limit(limit),
    .count(count), .busy(busy), .done(done), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         cout;
    logic         ovf;
  } snap_t;

  snap_t q[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  // Run model: a run is "active" from an accepted start until it reaches limit or is aborted.
  int m_count  = 0;
  bit m_active = 0, m_paused = 0, m_done = 0, m_cout = 0, m_ovf = 0;

  function automatic void model_edge();
    int sum;
    if (rst) begin
      m_count = 0; m_active = 0; m_paused = 0; m_done = 0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (abort) begin
        m_active = 0;
        m_paused = 0;
      end else if (!m_active) begin
        if (start) begin
          m_count = int'(init);
          m_cout  = 0;
          m_ovf   = 0;
          m_paused = 0;
          if (int'(init) >= int'(limit)) m_done = 1;
          else m_active = 1;
        end
      end else if (m_paused) begin
        if (!hold) m_paused = 0;
      end else if (hold) begin
        m_paused = 1;
      end else begin
        sum    = m_count + int'(step);
        m_cout = (sum >= (1 << W));
        if (sum >= int'(limit)) begin
          m_count  = int'(limit);
          m_ovf    = m_cout;
          m_active = 0;
          m_done   = 1;
        end else begin
          m_count = sum;
        end
      end
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.count = m_count[W-1:0];
    s.busy  = m_active;
    s.done  = m_done;
    s.cout  = m_cout;
    s.ovf   = m_ovf;
    return s;
  endfunction

  // Called one time unit after a rising edge: drive inputs, predict the next edge, queue the prediction.
  task automatic cycle(input bit s, input bit h, input bit a, input int i, input int st, input int l);
    start = s; hold = h; abort = a;
    init = i[W-1:0]; step = st[W-1:0]; limit = l[W-1:0];
    model_edge();
    @(posedge clk);
    #1;
    q.push_back(model_snap());
  endtask

  task automatic run_cycles(input int n, input int st, input int l);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, st, l);
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge arrives.
  task automatic pulse_reset();
    snap_t g;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    g = {count, busy, done, cout, ovf};
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL async_reset: got count=%02h busy=%b done=%b cout=%b ovf=%b, want all zero",
               g.count, g.busy, g.done, g.cout, g.ovf);
    end
    cycle(1, 0, 0, 8'h11, 1, 8'h40);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      snap_t e, g;
      e = q.pop_front();
      g = {count, busy, done, cout, ovf};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got count=%02h busy=%b done=%b cout=%b ovf=%b, want count=%02h busy=%b done=%b cout=%b ovf=%b",
                 phase, g.count, g.busy, g.done, g.cout, g.ovf, e.count, e.busy, e.done, e.cout, e.ovf);
      end
    end
  end

  initial begin
    // Reset held across two edges with start asserted: it must be ignored.
    cycle(1, 0, 0, 0, 1, 5);
    cycle(1, 0, 0, 0, 1, 5);
    rst = 1'b0;

    phase = "count_to_5";
    cycle(1, 0, 0, 8'h00, 8'h01, 8'h05);
    run_cycles(6, 1, 5);

    phase = "hold";
    cycle(1, 0, 0, 8'h00, 8'h01, 8'h05);
    run_cycles(2, 1, 5);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 1, 5);
    run_cycles(5, 1, 5);

    phase = "abort";
    cycle(1, 0, 0, 8'h00, 8'h01, 8'h05);
    run_cycles(3, 1, 5);
    cycle(0, 0, 1, 0, 1, 5);
    run_cycles(2, 1, 5);
    cycle(1, 0, 0, 8'h00, 8'h01, 8'h05);
    run_cycles(2, 1, 5);
    cycle(0, 0, 1, 0, 1, 5);

    phase = "carry_clamp";
    cycle(1, 0, 0, 8'hF0, 8'h20, 8'hFF);
    run_cycles(3, 8'h20, 8'hFF);

    phase = "init_past_limit";
    cycle(1, 0, 0, 8'h07, 8'h01, 8'h03);
    run_cycles(2, 1, 3);
    cycle(1, 0, 0, 8'h03, 8'h01, 8'h03);
    run_cycles(1, 1, 3);

    phase = "async_reset";
    cycle(1, 0, 0, 8'h10, 8'h03, 8'h80);
    run_cycles(3, 3, 8'h80);
    pulse_reset();
    cycle(1, 0, 1, 8'h22, 8'h01, 8'h40);
    run_cycles(2, 1, 8'h40);

    phase = "step_zero";
    cycle(1, 0, 0, 8'h03, 8'h00, 8'h09);
    run_cycles(10, 0, 9);
    cycle(0, 0, 1, 0, 0, 9);

    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      bit s, h, a;
      int i, st, l;
      s  = ($urandom_range(0, 99) < 20);
      h  = ($urandom_range(0, 99) < 15);
      a  = ($urandom_range(0, 99) < 3);
      i  = $urandom_range(0, 255);
      l  = $urandom_range(0, 255);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else cycle(s, h, a, i, st, l);
    end

    phase = "drain";
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
